seg_display_monitor: RTL and testbench
======================================

# seg_display_monitor

Receiving end of the four-digit multiplexed seven-segment interface. Samples the active-low anode strobes (an3..an0) and segment lines (a..g, dp), waits for each digit's anode to settle, and decodes each segment pattern back to its 4-bit character. It assembles one complete an3→an0 scan into a 16-bit word with a one-cycle valid pulse. Used on-chip as a loopback checker for the display path and as a self-test monitor on the board.

## Interface
- SETTLE_CYCLES, 4: consecutive cycles an anode pattern must hold before the digit is sampled (1..255).
- TIMEOUT_CYCLES, 65536: cycles without any anode change before lock is dropped (≥ 2*SETTLE_CYCLES).
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- an3, an2, an1, an0  in  1 each  anode strobes, active-low; asynchronous to clk.
- a, b, c, d, e, f, g  in  1 each  segment lines, active-low.
- dp  in  1  decimal point, active-low; captured, not decoded.
- digits  out  16  last complete frame: [15:12]=an3 char … [3:0]=an0 char.
- dp_bits  out  4  dp state per digit from the last frame, 1 = lit.
- frame_valid  out  1  one-cycle pulse when digits/dp_bits update.
- frame_err  out  1  one-cycle pulse on any protocol or decode error.
- locked  out  1  high after the first valid frame; low after a timeout or error.

## Operation
- All 12 inputs pass through a 2-flop synchronizer. Synchronizer reset value is all-ones, so everything reads inactive.
- Stability counter:
  - Reloads to 0 whenever the synchronized anode vector changes.
  - Saturates at SETTLE_CYCLES.
  - A "sample" event fires exactly once per dwell, in the cycle the counter reaches SETTLE_CYCLES.
- On each sample, the anode vector is classified:
  - One-hot-low: valid digit slot.
  - 4'b1111: blanking; ignored and does not break the frame.
  - Anything else: error.
- Decode: {a..g} maps to 0–F using the team's standard active-low hex pattern set. Any other pattern, including all-off, is invalid.
- FSM states: HUNT, CAPTURE.
  - HUNT: wait for a valid sample on an3, then store char3 and go to CAPTURE, expecting an2.
  - CAPTURE: the expected order is an2, an1, an0. Each valid sample on the expected anode stores its char and dp, then advances the expectation.
  - Sample on an0 completes the frame: load digits and dp_bits from the shadow registers, pulse frame_valid, set locked, return to HUNT with an3 expected.
  - Errors: wrong anode, multiple anodes active, or invalid segment pattern. Each pulses frame_err, clears locked, and returns to HUNT. The shadow registers are discarded and digits is left unchanged.
- A repeated sample on the same anode within one dwell cannot occur, because sampling is one-shot per dwell.
- Timeout: the idle counter counts cycles since the last anode change. At TIMEOUT_CYCLES it clears locked and forces HUNT. No frame_err is raised.

## Timing
- Reset values: digits=0, dp_bits=0, frame_valid=0, frame_err=0, locked=0, FSM=HUNT, all counters 0.
- Input to internal visibility: 2 cycles (synchronizer).
- Sample occurs SETTLE_CYCLES cycles after the synchronized anode change. Dwells shorter than SETTLE_CYCLES+1 cycles are never sampled.
- frame_valid, digits, dp_bits and locked update in the cycle after the an0 sample. digits and dp_bits hold until the next valid frame.
- frame_err is registered and pulses in the cycle after the offending sample.
- Simultaneous error and timeout: the error takes precedence and frame_err pulses.
- Reset asserted mid-frame: all state clears immediately. The first frame after release must start at an3.

## Structure
- Shared package seg_display_pkg holds:
  - the 16-entry active-low segment pattern constants (shared with the display driver's decoder);
  - the anode one-hot constants;
  - the FSM state enum.
- One sub-module, seg_to_char: purely combinational 7-bit pattern to {valid, 4-bit char}.
- Synchronizer, counters and FSM live in the top level.

## Test plan
- Drive "1234" (all dp off), dwell 10 cycles per anode, SETTLE=4 → digits=16'h1234, dp_bits=4'b0000, a single frame_valid pulse, locked=1.
- Drive "A0F9" with dp lit on an1 and 2 blanking cycles between dwells → digits=16'hA0F9, dp_bits=4'b0010, no frame_err.
- Scan an3, an1 (skipping an2) → frame_err pulse, locked=0, digits unchanged. The next correct an3..an0 frame is accepted.
- Scan with 3-cycle dwells, SETTLE=4 → no samples, no frame_valid. The timeout then drops locked, with no frame_err.
- Drive segment pattern 7'b1111111 on an1, then separately an2 and an1 low together → frame_err pulse in each case, FSM back in HUNT.
- Assert reset after the an2 sample → all outputs return to their reset values, and a full frame "5678" afterwards yields digits=16'h5678.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared constants and types for the seven-segment display path:
// active-low hex glyphs, anode strobe encodings and monitor FSM states.
package seg_display_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned CHAR_W  = 4;
    localparam int unsigned AN_W    = 4;
    localparam int unsigned SLOT_W  = 2;
    localparam int unsigned NUM_HEX = 16;

    // {a,b,c,d,e,f,g}, a in the MSB, 0 = segment lit
    localparam logic [SEG_W-1:0] SEG_HEX [NUM_HEX] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,   // 0 1 2 3
        7'h4C, 7'h24, 7'h20, 7'h0F,   // 4 5 6 7
        7'h00, 7'h04, 7'h08, 7'h60,   // 8 9 A b
        7'h31, 7'h42, 7'h30, 7'h38    // C d E F
    };

    // Index is the digit slot: AN_SEL[3] drives an3 low, AN_SEL[0] drives an0 low
    localparam logic [AN_W-1:0] AN_SEL [AN_W] = '{
        4'b1110, 4'b1101, 4'b1011, 4'b0111
    };
    localparam logic [AN_W-1:0] AN_BLANK = 4'b1111;

    localparam logic [SLOT_W-1:0] SLOT_FIRST = 2'd3;
    localparam logic [SLOT_W-1:0] SLOT_LAST  = 2'd0;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        CAPTURE = 1'b1
    } mon_state_e;

    typedef struct packed {
        logic              valid;
        logic [CHAR_W-1:0] value;
    } seg_char_t;

endpackage

// File: rtl/seg_display_monitor_seg_to_char.sv
// Combinational reverse lookup of an active-low segment pattern to its hex
// character; anything outside the glyph table (including all-off) is invalid.
module seg_to_char
    import seg_display_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output seg_char_t        decoded_c
);

    always_comb begin
        decoded_c = '0;
        for (int unsigned i = 0; i < NUM_HEX; i++) begin
            if (pattern == SEG_HEX[i]) begin
                decoded_c.valid = 1'b1;
                decoded_c.value = CHAR_W'(i);
            end
        end
    end

endmodule

// File: rtl/seg_display_monitor.sv
// Loopback monitor for the multiplexed four-digit display: resynchronises the
// strobes, samples each settled digit and reassembles full an3..an0 frames.
module seg_display_monitor
    import seg_display_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        an3,
    input  logic        an2,
    input  logic        an1,
    input  logic        an0,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    input  logic        dp,
    output logic [15:0] digits,
    output logic [3:0]  dp_bits,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        locked
);

    localparam int unsigned SYNC_W   = 12;
    localparam int unsigned STAB_W   = 8;
    localparam int unsigned IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned SHADOW_W = 3 * CHAR_W;

    // Two-flop synchroniser; all-ones reset so every line reads inactive
    logic [SYNC_W-1:0] sync_meta;
    logic [SYNC_W-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= '1;
            sync_q    <= '1;
        end else begin
            sync_meta <= {an3, an2, an1, an0, a, b, c, d, e, f, g, dp};
            sync_q    <= sync_meta;
        end
    end

    logic [AN_W-1:0]  an_s;
    logic [SEG_W-1:0] seg_s;
    logic             dp_s;

    assign an_s  = sync_q[SYNC_W-1 -: AN_W];
    assign seg_s = sync_q[SEG_W:1];
    assign dp_s  = sync_q[0];

    // Dwell tracking: settle counter for sampling, idle counter for lock timeout
    logic [AN_W-1:0]   an_prev;
    logic [STAB_W-1:0] stab_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              an_change_c;
    logic              sample_c;
    logic              timeout_c;

    assign an_change_c = (an_s != an_prev);
    assign sample_c    = !an_change_c && (stab_cnt == STAB_W'(SETTLE_CYCLES - 1));
    assign timeout_c   = !an_change_c && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_prev  <= AN_BLANK;
            stab_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            an_prev <= an_s;
            if (an_change_c) begin
                stab_cnt <= '0;
            end else if (stab_cnt != STAB_W'(SETTLE_CYCLES)) begin
                stab_cnt <= stab_cnt + STAB_W'(1);
            end
            if (an_change_c) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_W'(TIMEOUT_CYCLES)) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end

    // Anode classification: blank, single active slot, or malformed
    logic              an_blank_c;
    logic              an_onehot_c;
    logic [SLOT_W-1:0] slot_c;

    assign an_blank_c  = (an_s == AN_BLANK);
    assign an_onehot_c = $onehot(~an_s);

    always_comb begin
        slot_c = '0;
        for (int unsigned i = 0; i < AN_W; i++) begin
            if (an_s == AN_SEL[i]) begin
                slot_c = SLOT_W'(i);
            end
        end
    end

    seg_char_t dec_c;

    seg_to_char u_seg_to_char (
        .pattern   (seg_s),
        .decoded_c (dec_c)
    );

    // Frame FSM
    mon_state_e        state;
    mon_state_e        state_next;
    logic [SLOT_W-1:0] exp_slot;
    logic [SLOT_W-1:0] exp_slot_next;
    logic              store_c;
    logic              done_c;
    logic              err_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= HUNT;
            exp_slot <= SLOT_FIRST;
        end else begin
            state    <= state_next;
            exp_slot <= exp_slot_next;
        end
    end

    always_comb begin
        state_next    = state;
        exp_slot_next = exp_slot;
        store_c       = 1'b0;
        done_c        = 1'b0;
        err_c         = 1'b0;

        if (timeout_c) begin
            state_next    = HUNT;
            exp_slot_next = SLOT_FIRST;
        end

        if (sample_c && !an_blank_c) begin
            if (!an_onehot_c) begin
                err_c = 1'b1;
            end else if (state == HUNT) begin
                // Only the an3 slot can open a frame; other slots are skipped
                if (slot_c == SLOT_FIRST) begin
                    if (dec_c.valid) begin
                        store_c       = 1'b1;
                        state_next    = CAPTURE;
                        exp_slot_next = slot_c - SLOT_W'(1);
                    end else begin
                        err_c = 1'b1;
                    end
                end
            end else if ((slot_c != exp_slot) || !dec_c.valid) begin
                err_c = 1'b1;
            end else if (slot_c == SLOT_LAST) begin
                done_c        = 1'b1;
                state_next    = HUNT;
                exp_slot_next = SLOT_FIRST;
            end else begin
                store_c       = 1'b1;
                exp_slot_next = exp_slot - SLOT_W'(1);
            end
        end

        if (err_c) begin
            state_next    = HUNT;
            exp_slot_next = SLOT_FIRST;
        end
    end

    // Shadow holds an3..an1 of the frame in progress
    logic [SHADOW_W-1:0] shadow_chars;
    logic [2:0]          shadow_dp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_chars <= '0;
            shadow_dp    <= '0;
        end else if (store_c) begin
            case (slot_c)
                2'd3: begin
                    shadow_chars[11:8] <= dec_c.value;
                    shadow_dp[2]       <= ~dp_s;
                end
                2'd2: begin
                    shadow_chars[7:4] <= dec_c.value;
                    shadow_dp[1]      <= ~dp_s;
                end
                default: begin
                    shadow_chars[3:0] <= dec_c.value;
                    shadow_dp[0]      <= ~dp_s;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digits      <= '0;
            dp_bits     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            locked      <= 1'b0;
        end else begin
            frame_valid <= done_c;
            frame_err   <= err_c;
            if (done_c) begin
                digits  <= {shadow_chars, dec_c.value};
                dp_bits <= {shadow_dp, ~dp_s};
                locked  <= 1'b1;
            end else if (err_c || timeout_c) begin
                locked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_monitor.sv
// Randomised scoreboard bench for seg_display_monitor: a dwell-level reference
// model predicts frame/error pulses which a passive monitor checks.
module tb_seg_display_monitor;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 64;

    logic        clk;
    logic        reset;
    logic        an3, an2, an1, an0;
    logic        a, b, c, d, e, f, g, dp;
    logic [15:0] digits;
    logic [3:0]  dp_bits;
    logic        frame_valid;
    logic        frame_err;
    logic        locked;

    seg_display_monitor #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .an3         (an3),
        .an2         (an2),
        .an1         (an1),
        .an0         (an0),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .e           (e),
        .f           (f),
        .g           (g),
        .dp          (dp),
        .digits      (digits),
        .dp_bits     (dp_bits),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          is_err;
        logic [15:0] digits;
        logic [3:0]  dps;
    } ev_t;

    ev_t exp_q[$];

    // Lit segments per hex glyph, written the way a datasheet lists them
    string lit_tab [16] = '{
        "abcdef", "bc",     "abdeg", "abcdg",
        "bcfg",   "acdfg",  "acdefg", "abc",
        "abcdefg","abcdfg", "abcefg", "cdefg",
        "adef",   "bcdeg",  "adefg",  "aefg"
    };

    // Model state
    logic [3:0] m_an;
    int         m_run;
    bit         m_hunt;
    int         m_exp;
    bit         m_locked;
    logic [3:0] m_chars [4];
    bit         m_dps   [4];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endfunction

    function automatic logic [6:0] seg_for(input int v);
        string      s;
        logic [6:0] p;
        s = lit_tab[v];
        p = 7'h7F;
        for (int k = 0; k < s.len(); k++) begin
            p[6 - int'(s[k] - "a")] = 1'b0;
        end
        return p;
    endfunction

    function automatic bit decode(input logic [6:0] seg, output logic [3:0] v);
        v = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg_for(i) == seg) begin
                v = 4'(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [3:0] an_sel(input int slot);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << slot);
    endfunction

    function automatic void model_reset();
        m_an     = 4'hF;
        m_run    = 0;
        m_hunt   = 1'b1;
        m_exp    = 3;
        m_locked = 1'b0;
    endfunction

    function automatic void model_error();
        ev_t ev;
        ev.is_err = 1'b1;
        ev.digits = 16'h0;
        ev.dps    = 4'h0;
        exp_q.push_back(ev);
        m_locked = 1'b0;
        m_hunt   = 1'b1;
        m_exp    = 3;
    endfunction

    function automatic void model_sample(input logic [3:0] an, input logic [6:0] seg, input bit dpl);
        int         lows;
        int         slot;
        bit         ok;
        logic [3:0] v;
        ev_t        ev;
        lows = 0;
        slot = 0;
        for (int i = 0; i < 4; i++) begin
            if (an[i] == 1'b0) begin
                lows++;
                slot = i;
            end
        end
        if (lows == 0) return;
        ok = decode(seg, v);
        if (lows > 1) begin
            model_error();
            return;
        end
        if (m_hunt) begin
            if (slot != 3) return;
            if (!ok) begin
                model_error();
                return;
            end
            m_chars[3] = v;
            m_dps[3]   = dpl;
            m_hunt     = 1'b0;
            m_exp      = 2;
            return;
        end
        if (slot != m_exp || !ok) begin
            model_error();
            return;
        end
        m_chars[slot] = v;
        m_dps[slot]   = dpl;
        if (slot == 0) begin
            ev.is_err = 1'b0;
            ev.digits = {m_chars[3], m_chars[2], m_chars[1], m_chars[0]};
            ev.dps    = {m_dps[3], m_dps[2], m_dps[1], m_dps[0]};
            exp_q.push_back(ev);
            m_locked = 1'b1;
            m_hunt   = 1'b1;
            m_exp    = 3;
        end else begin
            m_exp--;
        end
    endfunction

    // One input cycle as seen by the model: a digit is read once its anode has
    // held SETTLE+1 cycles; lock is lost once it has held TIMEOUT+1 cycles.
    function automatic void model_step(input logic [3:0] an, input logic [6:0] seg, input bit dpl);
        if (an == m_an) begin
            m_run++;
        end else begin
            m_an  = an;
            m_run = 1;
        end
        if (m_run == int'(SETTLE) + 1) model_sample(an, seg, dpl);
        if (m_run == int'(TIMEOUT) + 1) begin
            m_locked = 1'b0;
            m_hunt   = 1'b1;
            m_exp    = 3;
        end
    endfunction

    task automatic set_pins(input logic [3:0] an, input logic [6:0] seg, input bit dpl);
        {an3, an2, an1, an0}    = an;
        {a, b, c, d, e, f, g}   = seg;
        dp                      = ~dpl;
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input bit dpl, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            set_pins(an, seg, dpl);
            model_step(an, seg, dpl);
        end
    endtask

    task automatic blank(input int n);
        drive(4'hF, 7'h7F, 1'b0, n);
    endtask

    task automatic send_frame(input logic [15:0] v, input logic [3:0] dps, input int dwell, input int gap);
        for (int s = 3; s >= 0; s--) begin
            drive(an_sel(s), seg_for(int'(v[s*4 +: 4])), dps[s], dwell);
            if (gap > 0) blank(gap);
        end
    endtask

    task automatic phase_end(input string name);
        blank(8);
        @(negedge clk);
        check({name, "_locked"}, 32'(locked), 32'(m_locked));
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_pins(4'hF, 7'h7F, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_dp_bits", 32'(dp_bits), 32'h0);
        check("rst_frame_valid", 32'(frame_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        ev_t ev;
        if (reset && (frame_valid || frame_err)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b digits=0x%0h, none expected at %0t",
                         frame_valid, frame_err, digits, $time);
            end else begin
                ev = exp_q.pop_front();
                check("pulse_err", 32'(frame_err), 32'(ev.is_err));
                check("pulse_valid", 32'(frame_valid), 32'(!ev.is_err));
                check("pulse_locked", 32'(locked), 32'(!ev.is_err));
                if (!ev.is_err) begin
                    check("frame_digits", 32'(digits), 32'(ev.digits));
                    check("frame_dp_bits", 32'(dp_bits), 32'(ev.dps));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          mode;
        int          dw;
        int          gap;
        logic [15:0] v;
        logic [3:0]  dps;

        reset = 1'b0;
        set_pins(4'hF, 7'h7F, 1'b0);
        model_reset();
        apply_reset();
        blank(5);

        send_frame(16'h1234, 4'b0000, 10, 0);
        phase_end("p1234");

        send_frame(16'hA0F9, 4'b0010, 10, 2);
        phase_end("pA0F9");

        drive(an_sel(3), seg_for(9), 1'b0, 10);
        drive(an_sel(1), seg_for(1), 1'b0, 10);
        drive(an_sel(0), seg_for(0), 1'b0, 10);
        blank(3);
        send_frame(16'hC0DE, 4'b1001, 10, 1);
        phase_end("pskip");

        send_frame(16'h4321, 4'b0000, 3, 0);
        send_frame(16'h8765, 4'b1111, 3, 0);
        phase_end("pshort");
        blank(70);
        @(negedge clk);
        check("timeout_locked", 32'(locked), 32'(m_locked));

        drive(an_sel(3), seg_for(1), 1'b0, 10);
        drive(an_sel(2), seg_for(2), 1'b0, 10);
        drive(an_sel(1), 7'h7F, 1'b0, 10);
        blank(4);
        drive(an_sel(3), seg_for(3), 1'b0, 10);
        drive(4'b1001, seg_for(4), 1'b0, 10);
        blank(4);
        send_frame(16'hBEEF, 4'b0100, 8, 0);
        phase_end("pbad");

        drive(an_sel(3), seg_for(5), 1'b0, 10);
        drive(an_sel(2), seg_for(6), 1'b0, 10);
        apply_reset();
        blank(5);
        send_frame(16'h5678, 4'b0000, 10, 0);
        phase_end("preset");

        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 9));
            v    = 16'($urandom);
            dps  = 4'($urandom);
            dw   = int'($urandom_range(3, 9));
            gap  = int'($urandom_range(0, 3));
            if (mode < 6) begin
                send_frame(v, dps, dw, gap);
            end else if (mode == 6) begin
                for (int s = 0; s < 4; s++) begin
                    drive(4'($urandom), 7'($urandom), 1'($urandom), int'($urandom_range(2, 8)));
                end
            end else if (mode == 7) begin
                for (int s = 3; s >= 0; s--) begin
                    if ($urandom_range(0, 3) == 0) begin
                        drive(an_sel(s), 7'($urandom), dps[s], dw);
                    end else begin
                        drive(an_sel(s), seg_for(int'(v[s*4 +: 4])), dps[s], dw);
                    end
                end
            end else begin
                for (int s = 3; s >= 0; s--) begin
                    drive(an_sel(s), seg_for(int'(v[s*4 +: 4])), dps[s], int'($urandom_range(3, 7)));
                    if (gap > 0) blank(gap);
                end
            end
        end
        phase_end("prandom");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
